// File: rtl/mem_cond_write_if.sv
// Bus bundle for the constant-time conditional memory writer.
// Slave side: start/select/address control in, both source read ports and the destination write port.
interface mem_cond_write_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
);
   logic             i_start;
   logic             i_sel;
   logic [AW-1:0]    i_start_addr;
   logic [AW-1:0]    i_end_addr;
   logic [AW-1:0]    i_dst_start_addr;
   logic [AW-1:0]    o_mem_in_addr;
   logic             o_mem_in_en;
   logic [WIDTH-1:0] i_mem_in_0;
   logic [WIDTH-1:0] i_mem_in_1;
   logic [AW-1:0]    o_mem_out_addr;
   logic             o_mem_out_en;
   logic [WIDTH-1:0] o_mem_out_data;
   logic             o_done;

   modport slave (
      input  i_start, i_sel,
      input  i_start_addr, i_end_addr, i_dst_start_addr,
      output o_mem_in_addr, o_mem_in_en,
      input  i_mem_in_0, i_mem_in_1,
      output o_mem_out_addr, o_mem_out_en, o_mem_out_data,
      output o_done
   );

   modport master (
      output i_start, i_sel,
      output i_start_addr, i_end_addr, i_dst_start_addr,
      input  o_mem_in_addr, o_mem_in_en,
      output i_mem_in_0, i_mem_in_1,
      input  o_mem_out_addr, o_mem_out_en, o_mem_out_data,
      input  o_done
   );
endinterface

// File: rtl/mem_cond_write.sv
// Constant-time conditional writer: copies a source word range from mem 0 or mem 1 into a destination.
// Ports: i_clk, i_rst_n (async active-low), bus (slave): control, shared source read port, dest write port, o_done.
module mem_cond_write #(
   parameter int WIDTH         = 32,
   parameter int MAX_MEM_DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   mem_cond_write_if.slave  bus
);
   localparam int AW = $clog2(MAX_MEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state;
   logic          sel_q;
   logic          rd_valid_q;
   logic          done_q;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] wr_addr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         sel_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         rd_addr    <= '0;
         wr_addr    <= '0;
      end else begin
         done_q <= 1'b0;
         if (rd_valid_q)
            wr_addr <= wr_addr + AW'(1);
         unique case (state)
            S_IDLE: begin
               if (bus.i_start) begin
                  sel_q   <= bus.i_sel;
                  rd_addr <= bus.i_start_addr;
                  wr_addr <= bus.i_dst_start_addr;
                  state   <= S_READ;
               end
            end
            S_READ: begin
               rd_valid_q <= 1'b1;
               if (rd_addr == bus.i_end_addr)
                  state <= S_DRAIN;
               else
                  rd_addr <= rd_addr + AW'(1);
            end
            S_DRAIN: begin
               // last read's data lands this cycle; write it, then stop
               rd_valid_q <= 1'b0;
               state      <= S_DONE;
            end
            S_DONE: begin
               done_q <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // both sources are always read; sel_q only steers the data mux
   assign bus.o_mem_in_en    = (state == S_READ);
   assign bus.o_mem_in_addr  = rd_addr;
   assign bus.o_mem_out_en   = rd_valid_q;
   assign bus.o_mem_out_addr = wr_addr;
   assign bus.o_mem_out_data = rd_valid_q
                             ? (sel_q ? bus.i_mem_in_1 : bus.i_mem_in_0)
                             : '0;
   assign bus.o_done         = done_q;
endmodule

// File: tb/tb_mem_cond_write.sv
// Scoreboard bench for mem_cond_write: directed transfers, expected read/write/done trace queued per start.
// Memory models: two sync-read sources and one destination array.
module tb_mem_cond_write;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   chk_off = 1'b0;

   typedef struct {
      int          c;
      logic [3:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t rd_q[$];
   exp_t wr_q[$];
   int   done_q[$];

   logic [31:0] src0 [16];
   logic [31:0] src1 [16];
   logic [31:0] dst  [16];
   logic [31:0] rd0, rd1;

   mem_cond_write_if #(.WIDTH(32), .AW(4)) bus ();

   mem_cond_write #(.WIDTH(32), .MAX_MEM_DEPTH(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (bus.o_mem_in_en) begin
         rd0 <= src0[bus.o_mem_in_addr];
         rd1 <= src1[bus.o_mem_in_addr];
      end
   assign bus.i_mem_in_0 = rd0;
   assign bus.i_mem_in_1 = rd1;

   always @(posedge clk)
      if (bus.o_mem_out_en) dst[bus.o_mem_out_addr] <= bus.o_mem_out_data;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a read, write or done
   always @(negedge clk) begin
      exp_t e;
      int   dc;
      if (!chk_off && rst_n) begin
         if (bus.o_mem_in_en) begin
            if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else begin
               e = rd_q.pop_front();
               check("rd_cycle", cyc, e.c);
               check("rd_addr", 32'(bus.o_mem_in_addr), 32'(e.a));
            end
         end
         if (bus.o_mem_out_en) begin
            if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
               e = wr_q.pop_front();
               check("wr_cycle", cyc, e.c);
               check("wr_addr", 32'(bus.o_mem_out_addr), 32'(e.a));
               check("wr_data", bus.o_mem_out_data, e.d);
            end
         end else if (bus.o_mem_out_data !== 32'd0)
            check("wr_data_idle", bus.o_mem_out_data, 32'd0);
         if (bus.o_done) begin
            if (done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else begin
               dc = done_q.pop_front();
               check("done_cycle", cyc, dc);
            end
         end
      end
   end

   // issue one start in the current cycle; returns one cycle later with start low
   task automatic run(input logic sel, input logic [3:0] s, input logic [3:0] e,
                      input logic [3:0] d, input bit push, output int n);
      int c0;
      n  = int'(4'(e - s)) + 1;
      c0 = cyc;
      bus.i_sel            = sel;
      bus.i_start_addr     = s;
      bus.i_end_addr       = e;
      bus.i_dst_start_addr = d;
      bus.i_start          = 1'b1;
      if (push) begin
         for (int i = 0; i < n; i++) begin
            rd_q.push_back('{c0 + 1 + i, 4'(s + 4'(i)), 32'd0});
            wr_q.push_back('{c0 + 2 + i, 4'(d + 4'(i)),
                             (sel ? 32'h200 : 32'h100) + 32'(4'(s + 4'(i)))});
         end
         done_q.push_back(c0 + n + 3);
      end
      @(posedge clk); #1;
      bus.i_start = 1'b0;
   endtask

   task automatic finish_run(input int n);
      repeat (n + 3) @(posedge clk);
      #1;
   endtask

   task automatic clear_dst();
      for (int i = 0; i < 16; i++) dst[i] = 32'd0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) begin
         src0[i] = 32'h100 + 32'(i);
         src1[i] = 32'h200 + 32'(i);
      end
      clear_dst();
      bus.i_start = 1'b0;
      bus.i_sel = 1'b0;
      bus.i_start_addr = '0;
      bus.i_end_addr = '0;
      bus.i_dst_start_addr = '0;
      #1;
      check("rst_in_en", 32'(bus.o_mem_in_en), 32'd0);
      check("rst_out_en", 32'(bus.o_mem_out_en), 32'd0);
      check("rst_out_data", bus.o_mem_out_data, 32'd0);
      check("rst_done", 32'(bus.o_done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: sel=0, 2..5 -> 8..11
      run(1'b0, 4'd2, 4'd5, 4'd8, 1'b1, n);
      finish_run(n);
      for (int i = 0; i < 4; i++) check("s1_dst", dst[8 + i], 32'h102 + 32'(i));

      // 2: same with sel=1, identical trace
      run(1'b1, 4'd2, 4'd5, 4'd8, 1'b1, n);
      finish_run(n);
      for (int i = 0; i < 4; i++) check("s2_dst", dst[8 + i], 32'h202 + 32'(i));

      // 3: source and destination wrap
      run(1'b1, 4'd14, 4'd1, 4'd15, 1'b1, n);
      finish_run(n);
      check("s3_dst15", dst[15], 32'h20E);
      check("s3_dst0", dst[0], 32'h20F);
      check("s3_dst1", dst[1], 32'h200);
      check("s3_dst2", dst[2], 32'h201);

      // 4: single word
      run(1'b0, 4'd7, 4'd7, 4'd3, 1'b1, n);
      finish_run(n);
      check("s4_dst3", dst[3], 32'h107);

      // 5: async reset mid-transfer
      clear_dst();
      chk_off = 1'b1;
      run(1'b0, 4'd2, 4'd5, 4'd8, 1'b0, n);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("s5_in_en", 32'(bus.o_mem_in_en), 32'd0);
      check("s5_out_en", 32'(bus.o_mem_out_en), 32'd0);
      check("s5_out_data", bus.o_mem_out_data, 32'd0);
      check("s5_done", 32'(bus.o_done), 32'd0);
      @(posedge clk); #1;
      check("s5_partial8", dst[8], 32'h102);
      check("s5_partial9", dst[9], 32'd0);
      check("s5_partial11", dst[11], 32'd0);
      rst_n = 1'b1;
      chk_off = 1'b0;
      @(posedge clk); #1;
      run(1'b0, 4'd2, 4'd5, 4'd8, 1'b1, n);
      finish_run(n);
      for (int i = 0; i < 4; i++) check("s5_dst", dst[8 + i], 32'h102 + 32'(i));

      // 6: start during S_READ ignored; start on o_done accepted back-to-back
      run(1'b1, 4'd4, 4'd6, 4'd10, 1'b1, n);
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (n + 1) @(posedge clk);
      #1;
      run(1'b0, 4'd14, 4'd1, 4'd15, 1'b1, n);
      finish_run(n);
      check("s6_dst10", dst[10], 32'h204);
      check("s6_dst12", dst[12], 32'h206);
      check("s6_dst15", dst[15], 32'h10E);
      check("s6_dst2", dst[2], 32'h101);

      repeat (3) @(posedge clk);
      #1;
      check("rd_q_empty", 32'(rd_q.size()), 32'd0);
      check("wr_q_empty", 32'(wr_q.size()), 32'd0);
      check("done_q_empty", 32'(done_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
